bp_fe_pc_gen_ftq: RTL and testbench
===================================

BP_FE_PC_GEN_FTQ -- requirements
Module: bp_fe_pc_gen_ftq

Interface
REQ-001 Parameter vaddr_width_p, default 39: virtual address width.
REQ-002 Parameter fetch_bytes_p, default 8: fetch block size in bytes; power of two, at least 4.
REQ-003 Parameter ftq_els_p, default 8: fetch-target-queue depth; power of two, at least 2.
REQ-004 Parameter md_width_p, default 64: opaque branch-metadata width.
REQ-005 clk_i  in  1  single clock; reset_i  in  1  synchronous, active-high reset.
REQ-006 redirect_v_i in 1, redirect_pc_i in vaddr_width_p: backend redirect.
REQ-007 ovr_v_i in 1, ovr_idx_i in log2(ftq_els_p), ovr_pc_i in vaddr_width_p: front-end override; oldest wrong entry index and corrected PC.
REQ-008 gen_pc_o out vaddr_width_p, gen_v_o out 1: predictor lookup address and request valid.
REQ-009 pred_v_i in 1, pred_taken_i in 1, pred_tgt_i in vaddr_width_p, pred_md_i in md_width_p: same-cycle prediction for gen_pc_o.
REQ-010 fetch_v_o out 1, fetch_ready_i in 1, fetch_pc_o out vaddr_width_p, fetch_taken_o out 1, fetch_md_o out md_width_p, fetch_idx_o out log2(ftq_els_p): issue port, valid/ready.
REQ-011 release_v_i in 1: frees the oldest issued entry.
REQ-012 full_o out 1, empty_o out 1, count_o out log2(ftq_els_p)+1: occupancy.

Function
REQ-013 The block SHALL hold three pointers, head (release), fetch (issue) and tail (enqueue), each with one extra wrap bit; head <= fetch <= tail in age order.
REQ-014 gen_v_o SHALL equal gen_active_r & ~full_o & ~redirect_v_i & ~ovr_v_i.
REQ-015 An enqueue SHALL occur when gen_v_o & pred_v_i; the entry written is {gen_pc, pred_taken_i, pred_tgt_i, pred_md_i}.
REQ-016 On enqueue, gen_pc SHALL advance to pred_tgt_i if pred_taken_i, else to (gen_pc with the low log2(fetch_bytes_p) bits cleared) + fetch_bytes_p, with modulo-2^vaddr_width_p wrap.
REQ-017 fetch_v_o SHALL be 1 when fetch != tail; the fetch fields SHALL be read combinationally from entry[fetch]; the fetch pointer SHALL advance on fetch_v_o & fetch_ready_i.
REQ-018 release_v_i SHALL advance head only when head != fetch; otherwise it is ignored.
REQ-019 Redirect SHALL, next cycle, set fetch=tail=head, gen_pc=redirect_pc_i and gen_active_r=1; issued-but-unreleased entries are discarded.
REQ-020 Override SHALL, next cycle, set tail=ovr_idx_i+1, fetch=min_age(fetch, ovr_idx_i+1) and gen_pc=ovr_pc_i.
REQ-021 An override whose ovr_idx_i is not in [head, tail) SHALL be ignored.
REQ-022 Priority SHALL be redirect > override > enqueue; issue and release in the same cycle as an override apply before truncation.
REQ-023 Simultaneous enqueue and release at full SHALL NOT enqueue, because full_o is evaluated from registered pointers.
REQ-024 full_o SHALL be 1 when tail-head == ftq_els_p; empty_o SHALL be 1 when tail == head; count_o SHALL equal tail-head.

Reset
REQ-025 On reset, all pointers SHALL be 0, gen_pc 0 and gen_active_r 0; fetch_v_o, gen_v_o and full_o SHALL be 0, empty_o 1 and count_o 0.
REQ-026 The block SHALL remain idle after reset until the first redirect_v_i.
REQ-027 A reset asserted mid-operation SHALL discard all entries in one cycle; queue storage need not be cleared.

Structure
REQ-028 Typedef bp_fe_ftq_entry_s and its declare/width macros SHALL live in bp_fe_pkg/bp_fe_defines.
REQ-029 Storage SHALL be one bsg_mem_1r1w (ftq_els_p x entry width) with an asynchronous read; pointer logic stays in this module.

Verification
REQ-030 Redirect to 0x1000 with pred_taken_i=0 -> enqueued PCs 0x1000, 0x1008, 0x1010, 0x1018; full_o=1 after 4 enqueues (ftq_els_p=4); gen_v_o=0.
REQ-031 Entry at 0x1008 predicted taken to 0x2004 -> next enqueued PCs are 0x2004 then 0x2008 (aligned increment).
REQ-032 Four entries, two issued, override idx=1 to 0x3000 -> count_o=2, fetch pointer=2, next enqueued PC 0x3000.
REQ-033 Redirect and override in the same cycle -> only the redirect takes effect; queue empty; gen_pc=redirect_pc_i.
REQ-034 gen_pc 0x7F_FFFF_FFF8 (vaddr_width_p=39), not taken -> next gen_pc 0x0; release_v_i with head==fetch -> no change in count_o.
REQ-035 Reset asserted with 3 entries queued -> next cycle count_o=0, fetch_v_o=0, gen_v_o=0 until a redirect.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Front-end shared types: FTQ entry layout macros and the per-cycle queue operation encoding.
`ifndef BP_FE_DEFINES_SVH
`define BP_FE_DEFINES_SVH

`define BP_FE_DECLARE_FTQ_ENTRY_S(vaddr_width_mp, md_width_mp) \
    typedef struct packed { \
        logic [(vaddr_width_mp)-1:0] pc; \
        logic                        taken; \
        logic [(vaddr_width_mp)-1:0] tgt; \
        logic [(md_width_mp)-1:0]    md; \
    } bp_fe_ftq_entry_s

`define BP_FE_FTQ_ENTRY_WIDTH(vaddr_width_mp, md_width_mp) \
    (2*(vaddr_width_mp) + 1 + (md_width_mp))

`endif

package bp_fe_pkg;

    // Which pointer update wins this cycle; ordered so redirect dominates.
    typedef enum logic [1:0] {
        e_ftq_idle     = 2'd0,
        e_ftq_enqueue  = 2'd1,
        e_ftq_override = 2'd2,
        e_ftq_redirect = 2'd3
    } bp_fe_ftq_op_e;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module bsg_mem_1r1w
#(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int addr_width_lp = $clog2(els_p)
)
(
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_pc_gen_ftq.sv
// PC generator feeding a fetch target queue with head/fetch/tail pointers,
// backend redirect and front-end override recovery.
module bp_fe_pc_gen_ftq
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int fetch_bytes_p = 8,
    parameter int ftq_els_p     = 8,
    parameter int md_width_p    = 64,
    localparam int idx_w_lp = $clog2(ftq_els_p),
    localparam int ptr_w_lp = idx_w_lp + 1
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,

    input  logic                     ovr_v_i,
    input  logic [idx_w_lp-1:0]      ovr_idx_i,
    input  logic [vaddr_width_p-1:0] ovr_pc_i,

    output logic [vaddr_width_p-1:0] gen_pc_o,
    output logic                     gen_v_o,

    input  logic                     pred_v_i,
    input  logic                     pred_taken_i,
    input  logic [vaddr_width_p-1:0] pred_tgt_i,
    input  logic [md_width_p-1:0]    pred_md_i,

    output logic                     fetch_v_o,
    input  logic                     fetch_ready_i,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    output logic                     fetch_taken_o,
    output logic [md_width_p-1:0]    fetch_md_o,
    output logic [idx_w_lp-1:0]      fetch_idx_o,

    input  logic                     release_v_i,

    output logic                     full_o,
    output logic                     empty_o,
    output logic [ptr_w_lp-1:0]      count_o
);

    `BP_FE_DECLARE_FTQ_ENTRY_S(vaddr_width_p, md_width_p);
    localparam int entry_width_lp = `BP_FE_FTQ_ENTRY_WIDTH(vaddr_width_p, md_width_p);

    // Sequential successor: align down to the fetch block, then step one block.
    function automatic logic [vaddr_width_p-1:0] seq_next_pc(input logic [vaddr_width_p-1:0] pc);
        return (pc & ~vaddr_width_p'(fetch_bytes_p - 1)) + vaddr_width_p'(fetch_bytes_p);
    endfunction

    logic [ptr_w_lp-1:0]      head_r, fetch_r, tail_r;
    logic [vaddr_width_p-1:0] gen_pc_r;
    logic                     gen_active_r;

    logic [ptr_w_lp-1:0] count;
    logic                enq, issue, rel;
    logic [ptr_w_lp-1:0] head_adv, fetch_adv;

    assign count   = tail_r - head_r;
    assign full_o  = (count == ptr_w_lp'(ftq_els_p));
    assign empty_o = (tail_r == head_r);
    assign count_o = count;

    assign gen_pc_o = gen_pc_r;
    assign gen_v_o  = gen_active_r & ~full_o & ~redirect_v_i & ~ovr_v_i;
    assign enq      = gen_v_o & pred_v_i;

    assign fetch_v_o   = (fetch_r != tail_r);
    assign fetch_idx_o = fetch_r[idx_w_lp-1:0];
    assign issue       = fetch_v_o & fetch_ready_i;
    assign rel         = release_v_i & (head_r != fetch_r);

    assign head_adv  = head_r  + ptr_w_lp'(rel);
    assign fetch_adv = fetch_r + ptr_w_lp'(issue);

    // Override bookkeeping: all ages are measured from the registered head.
    logic [idx_w_lp-1:0] ovr_off;
    logic [ptr_w_lp-1:0] ovr_len, ovr_tail, fetch_age, fetch_ovr;
    logic                ovr_hit;

    assign ovr_off   = ovr_idx_i - head_r[idx_w_lp-1:0];
    assign ovr_len   = ptr_w_lp'(ovr_off) + ptr_w_lp'(1);
    assign ovr_hit   = ovr_v_i & (ptr_w_lp'(ovr_off) < count);
    assign ovr_tail  = head_r + ovr_len;
    assign fetch_age = fetch_adv - head_r;
    assign fetch_ovr = (fetch_age > ovr_len) ? ovr_tail : fetch_adv;

    bp_fe_ftq_op_e op;

    always_comb begin
        op = e_ftq_idle;
        if (redirect_v_i) begin
            op = e_ftq_redirect;
        end else if (ovr_hit) begin
            op = e_ftq_override;
        end else if (enq) begin
            op = e_ftq_enqueue;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r       <= '0;
            fetch_r      <= '0;
            tail_r       <= '0;
            gen_pc_r     <= '0;
            gen_active_r <= 1'b0;
        end else begin
            head_r <= head_adv;
            unique case (op)
                e_ftq_redirect: begin
                    fetch_r      <= head_adv;
                    tail_r       <= head_adv;
                    gen_pc_r     <= redirect_pc_i;
                    gen_active_r <= 1'b1;
                end
                e_ftq_override: begin
                    fetch_r  <= fetch_ovr;
                    tail_r   <= ovr_tail;
                    gen_pc_r <= ovr_pc_i;
                end
                e_ftq_enqueue: begin
                    fetch_r  <= fetch_adv;
                    tail_r   <= tail_r + ptr_w_lp'(1);
                    gen_pc_r <= pred_taken_i ? pred_tgt_i : seq_next_pc(gen_pc_r);
                end
                default: begin
                    fetch_r <= fetch_adv;
                end
            endcase
        end
    end

    bp_fe_ftq_entry_s             wr_entry, rd_entry;
    logic [entry_width_lp-1:0]    rd_data;

    assign wr_entry = '{pc: gen_pc_r, taken: pred_taken_i, tgt: pred_tgt_i, md: pred_md_i};

    bsg_mem_1r1w #(
        .width_p (entry_width_lp),
        .els_p   (ftq_els_p)
    ) ftq_mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (tail_r[idx_w_lp-1:0]),
        .w_data_i (wr_entry),
        .r_addr_i (fetch_r[idx_w_lp-1:0]),
        .r_data_o (rd_data)
    );

    assign rd_entry      = bp_fe_ftq_entry_s'(rd_data);
    assign fetch_pc_o    = rd_entry.pc;
    assign fetch_taken_o = rd_entry.taken;
    assign fetch_md_o    = rd_entry.md;

    // Target is retained per entry for replay but is not presented on the issue port.
    logic unused_tgt;
    assign unused_tgt = ^rd_entry.tgt;

endmodule

// File: tb/tb_bp_fe_pc_gen_ftq.sv
// Bench for bp_fe_pc_gen_ftq: directed scenarios plus random traffic against a queue-level model.
module tb_bp_fe_pc_gen_ftq;

    localparam int VW  = 39;
    localparam int FB  = 8;
    localparam int ELS = 4;
    localparam int MDW = 16;
    localparam int IW  = 2;
    localparam logic [63:0] VMASK = (64'd1 << VW) - 64'd1;

    logic clk = 1'b0;
    logic reset_i;
    logic redirect_v_i;
    logic [VW-1:0] redirect_pc_i;
    logic ovr_v_i;
    logic [IW-1:0] ovr_idx_i;
    logic [VW-1:0] ovr_pc_i;
    logic [VW-1:0] gen_pc_o;
    logic gen_v_o;
    logic pred_v_i, pred_taken_i;
    logic [VW-1:0] pred_tgt_i;
    logic [MDW-1:0] pred_md_i;
    logic fetch_v_o, fetch_ready_i;
    logic [VW-1:0] fetch_pc_o;
    logic fetch_taken_o;
    logic [MDW-1:0] fetch_md_o;
    logic [IW-1:0] fetch_idx_o;
    logic release_v_i;
    logic full_o, empty_o;
    logic [IW:0] count_o;

    always #5 clk = ~clk;

    bp_fe_pc_gen_ftq #(
        .vaddr_width_p (VW),
        .fetch_bytes_p (FB),
        .ftq_els_p     (ELS),
        .md_width_p    (MDW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .ovr_v_i       (ovr_v_i),
        .ovr_idx_i     (ovr_idx_i),
        .ovr_pc_i      (ovr_pc_i),
        .gen_pc_o      (gen_pc_o),
        .gen_v_o       (gen_v_o),
        .pred_v_i      (pred_v_i),
        .pred_taken_i  (pred_taken_i),
        .pred_tgt_i    (pred_tgt_i),
        .pred_md_i     (pred_md_i),
        .fetch_v_o     (fetch_v_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_taken_o (fetch_taken_o),
        .fetch_md_o    (fetch_md_o),
        .fetch_idx_o   (fetch_idx_o),
        .release_v_i   (release_v_i),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .count_o       (count_o)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: queue front is the oldest unreleased entry; m_iss of them have been issued.
    typedef struct packed {
        logic [VW-1:0]  pc;
        logic           taken;
        logic [MDW-1:0] md;
    } ent_t;

    ent_t        mq[$];
    int          m_iss  = 0;
    int          m_head = 0;
    logic [63:0] m_pc   = 64'd0;
    bit          m_act  = 1'b0;

    task automatic idle();
        reset_i       = 1'b0;
        redirect_v_i  = 1'b0;
        redirect_pc_i = '0;
        ovr_v_i       = 1'b0;
        ovr_idx_i     = '0;
        ovr_pc_i      = '0;
        pred_v_i      = 1'b0;
        pred_taken_i  = 1'b0;
        pred_tgt_i    = '0;
        pred_md_i     = '0;
        fetch_ready_i = 1'b0;
        release_v_i   = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_pc();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[VW-1:0];
    endfunction

    // Called at a negedge with inputs driven: compare, advance the model, move to next negedge.
    task automatic tick();
        bit   gv, fv, iss, rel, enq, ok;
        int   off, nl;
        ent_t e;
        #1;
        gv = m_act && (mq.size() < ELS) && !redirect_v_i && !ovr_v_i;
        fv = m_iss < mq.size();
        check("gen_v",   gen_v_o,   gv);
        check("gen_pc",  gen_pc_o,  m_pc);
        check("fetch_v", fetch_v_o, fv);
        check("count",   count_o,   mq.size());
        check("full",    full_o,    mq.size() == ELS);
        check("empty",   empty_o,   mq.size() == 0);
        if (fv) begin
            check("fetch_pc",    fetch_pc_o,    mq[m_iss].pc);
            check("fetch_taken", fetch_taken_o, mq[m_iss].taken);
            check("fetch_md",    fetch_md_o,    mq[m_iss].md);
            check("fetch_idx",   fetch_idx_o,   (m_head + m_iss) % ELS);
        end
        if (reset_i) begin
            mq.delete();
            m_iss = 0; m_head = 0; m_pc = 64'd0; m_act = 1'b0;
        end else begin
            enq = gv && pred_v_i;
            rel = release_v_i && (m_iss > 0);
            iss = fv && fetch_ready_i;
            off = (int'(ovr_idx_i) - m_head + ELS) % ELS;
            ok  = ovr_v_i && (off < mq.size());
            if (iss) m_iss++;
            if (rel) begin
                void'(mq.pop_front());
                m_iss--;
                m_head = (m_head + 1) % ELS;
            end
            if (redirect_v_i) begin
                mq.delete();
                m_iss = 0;
                m_pc  = 64'(redirect_pc_i);
                m_act = 1'b1;
            end else if (ok) begin
                nl = off + 1 - int'(rel);
                while (mq.size() > nl) void'(mq.pop_back());
                if (m_iss > nl) m_iss = nl;
                m_pc = 64'(ovr_pc_i);
            end else if (enq) begin
                e.pc = m_pc[VW-1:0]; e.taken = pred_taken_i; e.md = pred_md_i;
                mq.push_back(e);
                m_pc = pred_taken_i ? 64'(pred_tgt_i)
                                    : (((m_pc & ~64'(FB - 1)) + 64'(FB)) & VMASK);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_count",   count_o,   0);
        check("rst_empty",   empty_o,   1);
        check("rst_full",    full_o,    0);
        check("rst_fetch_v", fetch_v_o, 0);
        check("rst_gen_v",   gen_v_o,   0);
        check("rst_gen_pc",  gen_pc_o,  0);

        // Idle until the first redirect even with predictions offered.
        pred_v_i = 1'b1;
        repeat (3) tick();
        check("idle_gen_v", gen_v_o, 0);

        // Sequential fill from 0x1000 up to full.
        redirect_v_i = 1'b1; redirect_pc_i = 39'h1000;
        tick();
        redirect_v_i = 1'b0;
        repeat (4) tick();
        #1;
        check("fill_full",  full_o,  1);
        check("fill_gen_v", gen_v_o, 0);
        check("fill_count", count_o, 4);
        pred_v_i = 1'b0; fetch_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_pc", fetch_pc_o, 64'h1000 + 64'(8 * i));
            tick();
        end
        fetch_ready_i = 1'b0;

        // Taken prediction to an unaligned target, then aligned increments.
        redirect_v_i = 1'b1; redirect_pc_i = 39'h1000;
        tick();
        redirect_v_i = 1'b0; pred_v_i = 1'b1; pred_taken_i = 1'b0;
        tick();
        pred_taken_i = 1'b1; pred_tgt_i = 39'h2004;
        tick();
        #1;
        check("taken_gen_pc", gen_pc_o, 64'h2004);
        pred_taken_i = 1'b0;
        tick();
        #1;
        check("aligned_gen_pc", gen_pc_o, 64'h2008);
        tick();

        // Two issued, override entry 1.
        pred_v_i = 1'b0; fetch_ready_i = 1'b1;
        repeat (2) tick();
        fetch_ready_i = 1'b0;
        ovr_v_i = 1'b1; ovr_idx_i = 2'd1; ovr_pc_i = 39'h3000;
        tick();
        ovr_v_i = 1'b0;
        #1;
        check("ovr_count",     count_o,     2);
        check("ovr_fetch_idx", fetch_idx_o, 2);
        check("ovr_gen_pc",    gen_pc_o,    64'h3000);
        pred_v_i = 1'b1;
        tick();
        pred_v_i = 1'b0;
        #1;
        check("ovr_next_pc", fetch_pc_o, 64'h3000);

        // Redirect beats a same-cycle override.
        redirect_v_i = 1'b1; redirect_pc_i = 39'h5000;
        ovr_v_i = 1'b1; ovr_idx_i = 2'd0; ovr_pc_i = 39'h6000;
        tick();
        redirect_v_i = 1'b0; ovr_v_i = 1'b0;
        #1;
        check("rd_ovr_empty",  empty_o,  1);
        check("rd_ovr_gen_pc", gen_pc_o, 64'h5000);

        // Address wrap, then a release with nothing issued.
        redirect_v_i = 1'b1; redirect_pc_i = 39'h7F_FFFF_FFF8;
        tick();
        redirect_v_i = 1'b0; pred_v_i = 1'b1;
        tick();
        pred_v_i = 1'b0;
        #1;
        check("wrap_gen_pc", gen_pc_o, 0);
        release_v_i = 1'b1;
        tick();
        release_v_i = 1'b0;
        #1;
        check("rel_noop_count", count_o, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset_i       = ($urandom_range(0, 299) == 0);
            redirect_v_i  = ($urandom_range(0, 39) == 0);
            redirect_pc_i = rand_pc();
            ovr_v_i       = ($urandom_range(0, 19) == 0);
            ovr_idx_i     = IW'($urandom_range(0, ELS - 1));
            ovr_pc_i      = rand_pc();
            pred_v_i      = ($urandom_range(0, 9) < 7);
            pred_taken_i  = ($urandom_range(0, 9) < 3);
            pred_tgt_i    = rand_pc();
            pred_md_i     = MDW'($urandom());
            fetch_ready_i = $urandom_range(0, 1);
            release_v_i   = ($urandom_range(0, 9) < 4);
            tick();
        end
        idle();

        // Reset with three entries queued.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        redirect_v_i = 1'b1; redirect_pc_i = 39'h8000;
        tick();
        redirect_v_i = 1'b0; pred_v_i = 1'b1;
        repeat (3) tick();
        pred_v_i = 1'b0;
        #1;
        check("pre_rst_count", count_o, 3);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("post_rst_count",   count_o,   0);
        check("post_rst_fetch_v", fetch_v_o, 0);
        pred_v_i = 1'b1;
        repeat (3) tick();
        #1;
        check("post_rst_gen_v", gen_v_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
